bird_flight_ctrl: RTL and testbench

//  Per-frame flight sequencer for the 32x32 bird sprite. Integrates gravity and flap impulses once per

---
 rtl/bird_flight_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bird_flight_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bird_flight_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bird_flight_ctrl
//  Description : Per-frame flight sequencer for the 32x32 bird sprite.
//                Integrates gravity and flap impulses once per video frame,
//                drives the sprite origin and sprite ctrl word, and runs the
//                game life-cycle IDLE -> FLY -> FALL -> DEAD.
//  Ports       : clk        - system clock
//                reset_n    - asynchronous active-low reset
//                frame_tick - one-cycle pulse per video frame
//                flap       - debounced flap button (level)
//                start      - start / restart request (level)
//                collide    - collision flag from pipe logic (level)
//                x0, y0     - sprite origin (pixels)
//                ctrl       - sprite ctrl word {color[1:0], auto, id[1:0]}
//                alive      - high while the bird is flying
//                score      - frames survived in FLY, saturating at 1023
//  Revision    : 1.0 - initial release
// ============================================================================
module bird_flight_ctrl #(
    parameter int         X_POS   = 100,
    parameter int         Y_START = 200,
    parameter int         Y_MIN   = 0,
    parameter int         Y_MAX   = 448,
    parameter int         GRAVITY = 1,
    parameter int         FLAP_V  = 8,
    parameter int         VMAX    = 10,
    parameter logic [1:0] COLOR   = 2'b00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        start,
    input  logic        collide,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic [4:0]  ctrl,
    output logic        alive,
    output logic [9:0]  score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_FALL = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    localparam logic [10:0]        C_X_POS     = 11'(X_POS);
    localparam logic [10:0]        C_Y_START   = 11'(Y_START);
    localparam logic [10:0]        C_Y_MIN11   = 11'(Y_MIN);
    localparam logic [10:0]        C_Y_MAX11   = 11'(Y_MAX);
    localparam logic signed [11:0] C_Y_MIN12   = 12'(Y_MIN);
    localparam logic signed [11:0] C_Y_MAX12   = 12'(Y_MAX);
    localparam logic signed [6:0]  C_GRAVITY7  = 7'(GRAVITY);
    localparam logic signed [6:0]  C_VMAX7     = 7'(VMAX);
    localparam logic signed [5:0]  C_VMAX6     = 6'(VMAX);
    localparam logic signed [5:0]  C_FLAP_VEL  = 6'(-FLAP_V);
    localparam logic [9:0]         C_SCORE_MAX = 10'd1023;
    localparam logic [4:0]         C_CTRL_LIVE = {COLOR, 1'b1, 2'b00};
    localparam logic [4:0]         C_CTRL_DOWN = {COLOR, 1'b0, 2'b11};

    state_t             r_state, w_state_n;
    logic signed [5:0]  r_vel, w_vel_n;
    logic [10:0]        r_y, w_y_n;
    logic [10:0]        r_x;
    logic [9:0]         r_score, w_score_n;
    logic               r_flap_d;
    logic               r_flap_pend, w_flap_pend_n;
    logic [4:0]         r_ctrl, w_ctrl_n;
    logic               r_alive, w_alive_n;

    logic               w_flap_edge;
    logic               w_flap_now;
    logic signed [6:0]  w_vel_inc;
    logic signed [5:0]  w_vel_grav;
    logic signed [5:0]  w_vel_fly;
    logic signed [11:0] w_y_fly;
    logic signed [11:0] w_y_fall;

    // A flap edge arriving on the same cycle as frame_tick counts for that tick.
    assign w_flap_edge = flap & ~r_flap_d;
    assign w_flap_now  = r_flap_pend | w_flap_edge;

    // Gravity step with terminal-velocity clamp; 7 bits so the sum cannot wrap.
    assign w_vel_inc  = $signed({r_vel[5], r_vel}) + C_GRAVITY7;
    assign w_vel_grav = (w_vel_inc > C_VMAX7) ? C_VMAX6 : w_vel_inc[5:0];
    assign w_vel_fly  = w_flap_now ? C_FLAP_VEL : w_vel_grav;

    // Candidate heights in 12-bit signed so going above the ceiling is visible.
    assign w_y_fly  = $signed({1'b0, r_y}) + $signed({{6{w_vel_fly[5]}}, w_vel_fly});
    assign w_y_fall = $signed({1'b0, r_y}) + $signed({{6{w_vel_grav[5]}}, w_vel_grav});

    always_comb begin
        w_state_n     = r_state;
        w_vel_n       = r_vel;
        w_y_n         = r_y;
        w_score_n     = r_score;
        w_flap_pend_n = r_flap_pend | w_flap_edge;

        case (r_state)
            ST_IDLE: begin
                w_y_n   = C_Y_START;
                w_vel_n = '0;
                if (start) begin
                    w_state_n = ST_FLY;
                    w_score_n = '0;
                end
            end
            ST_FLY: begin
                // Collision takes priority over a coincident frame tick.
                if (collide) begin
                    w_state_n = ST_FALL;
                    w_vel_n   = '0;
                end else if (frame_tick) begin
                    w_flap_pend_n = 1'b0;
                    w_vel_n       = w_vel_fly;
                    w_score_n     = (r_score == C_SCORE_MAX) ? r_score : r_score + 10'd1;
                    if (w_y_fly < C_Y_MIN12) begin
                        w_y_n   = C_Y_MIN11;
                        w_vel_n = '0;
                    end else if (w_y_fly >= C_Y_MAX12) begin
                        w_y_n     = C_Y_MAX11;
                        w_vel_n   = '0;
                        w_state_n = ST_DEAD;
                    end else begin
                        w_y_n = w_y_fly[10:0];
                    end
                end
            end
            ST_FALL: begin
                if (frame_tick) begin
                    w_vel_n = w_vel_grav;
                    if (w_y_fall >= C_Y_MAX12) begin
                        w_y_n     = C_Y_MAX11;
                        w_state_n = ST_DEAD;
                    end else begin
                        w_y_n = w_y_fall[10:0];
                    end
                end
            end
            ST_DEAD: begin
                if (start) begin
                    w_state_n = ST_IDLE;
                    w_y_n     = C_Y_START;
                    w_vel_n   = '0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        // A pending flap never carries across a life-cycle transition.
        if (w_state_n != r_state) begin
            w_flap_pend_n = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        w_alive_n = (w_state_n == ST_FLY);
        w_ctrl_n  = (w_state_n == ST_FALL || w_state_n == ST_DEAD) ? C_CTRL_DOWN : C_CTRL_LIVE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_vel       <= '0;
            r_y         <= C_Y_START;
            r_x         <= C_X_POS;
            r_score     <= '0;
            r_flap_d    <= 1'b0;
            r_flap_pend <= 1'b0;
            r_ctrl      <= C_CTRL_LIVE;
            r_alive     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_vel       <= w_vel_n;
            r_y         <= w_y_n;
            r_x         <= C_X_POS;
            r_score     <= w_score_n;
            r_flap_d    <= flap;
            r_flap_pend <= w_flap_pend_n;
            r_ctrl      <= w_ctrl_n;
            r_alive     <= w_alive_n;
        end
    end

    assign x0    = r_x;
    assign y0    = r_y;
    assign ctrl  = r_ctrl;
    assign alive = r_alive;
    assign score = r_score;

endmodule
`default_nettype wire

// File: tb/tb_bird_flight_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bird_flight_ctrl
//  Description : Self-checking bench for bird_flight_ctrl. Expected sprite
//                state is queued when each step is driven and compared once
//                the DUT has registered the step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bird_flight_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_tick;
    logic        flap;
    logic        start;
    logic        collide;
    logic [10:0] x0;
    logic [10:0] y0;
    logic [4:0]  ctrl;
    logic        alive;
    logic [9:0]  score;

    bird_flight_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .flap       (flap),
        .start      (start),
        .collide    (collide),
        .x0         (x0),
        .y0         (y0),
        .ctrl       (ctrl),
        .alive      (alive),
        .score      (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [10:0] y;
        logic [4:0]  ctrl;
        logic        alive;
        logic [9:0]  score;
        logic        chk_score;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [4:0] CTRL_LIVE = 5'b00100;
    localparam logic [4:0] CTRL_DOWN = 5'b00011;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int y, input logic [4:0] c,
                        input logic a, input int s, input logic cs);
        exp_t e;
        e.tag = tag; e.y = 11'(y); e.ctrl = c; e.alive = a;
        e.score = 10'(s); e.chk_score = cs;
        q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = q.pop_front();
            chk({e.tag, "_x0"},    16'(x0),    16'd100);
            chk({e.tag, "_y0"},    16'(y0),    16'(e.y));
            chk({e.tag, "_ctrl"},  16'(ctrl),  16'(e.ctrl));
            chk({e.tag, "_alive"}, 16'(alive), 16'(e.alive));
            if (e.chk_score) chk({e.tag, "_score"}, 16'(score), 16'(e.score));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  my, mv, sc, ny;
        bit  dead;

        reset_n = 1'b0; frame_tick = 1'b0; flap = 1'b0; start = 1'b0; collide = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 200, CTRL_LIVE, 1'b0, 0, 1'b1);
        check_out();
        reset_n = 1'b1;
        push("idle_hold", 200, CTRL_LIVE, 1'b0, 0, 1'b1);
        tick();
        check_out();

        // Gravity from rest: 201, 203, 206.
        push("fly_enter", 200, CTRL_LIVE, 1'b1, 0, 1'b1);
        start = 1'b1; cyc(); start = 1'b0;
        check_out();
        push("grav1", 201, CTRL_LIVE, 1'b1, 1, 1'b1); tick(); check_out();
        push("grav2", 203, CTRL_LIVE, 1'b1, 2, 1'b1); tick(); check_out();
        push("grav3", 206, CTRL_LIVE, 1'b1, 3, 1'b1); tick(); check_out();
        push("no_tick_hold", 206, CTRL_LIVE, 1'b1, 3, 1'b1); cyc(); check_out();

        // Flap captured between ticks, then consumed by the next tick.
        push("flap_pending", 206, CTRL_LIVE, 1'b1, 3, 1'b1);
        flap = 1'b1; cyc(); check_out();
        push("flap_up", 198, CTRL_LIVE, 1'b1, 4, 1'b1); tick(); check_out();
        flap = 1'b0;
        push("after_flap", 191, CTRL_LIVE, 1'b1, 5, 1'b1); tick(); check_out();
        my = 191; mv = -7; sc = 5;

        // Flap on every frame (edge coincident with tick) up to the ceiling.
        for (int k = 0; k < 24; k++) begin
            mv = -8; my = my + mv; sc++;
            if (my < 0) begin my = 0; mv = 0; end
            push("ceiling", my, CTRL_LIVE, 1'b1, sc, 1'b1);
            flap = 1'b1; tick(); flap = 1'b0;
            check_out();
            cyc();
        end
        push("ceiling_clamp", 0, CTRL_LIVE, 1'b1, 29, 1'b1); cyc(); check_out();

        // Free fall: velocity saturates at 10, then on to the floor.
        dead = 1'b0;
        for (int k = 0; k < 100 && !dead; k++) begin
            mv = (mv + 1 > 10) ? 10 : mv + 1;
            ny = my + mv;
            sc++;
            if (ny >= 448) begin
                dead = 1'b1;
                push("floor_dead", 448, CTRL_DOWN, 1'b0, sc, 1'b0);
            end else begin
                my = ny;
                push("free_fall", my, CTRL_LIVE, 1'b1, sc, 1'b1);
            end
            tick();
            check_out();
        end
        chk("floor_reached", 16'(dead), 16'd1);

        // DEAD ignores flaps and ticks; start returns to IDLE, then FLY.
        push("dead_frozen", 448, CTRL_DOWN, 1'b0, 0, 1'b0);
        flap = 1'b1; tick(); flap = 1'b0; check_out();
        push("restart_idle", 200, CTRL_LIVE, 1'b0, 0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0; check_out();
        push("idle_tick", 200, CTRL_LIVE, 1'b0, 0, 1'b0); tick(); check_out();
        push("refly", 200, CTRL_LIVE, 1'b1, 0, 1'b1);
        start = 1'b1; cyc(); start = 1'b0; check_out();

        // Climb-free descent to 245, then collide on a frame tick.
        my = 200; mv = 0; sc = 0;
        for (int k = 0; k < 9; k++) begin
            mv++; my = my + mv; sc++;
            push("pre_collide", my, CTRL_LIVE, 1'b1, sc, 1'b1);
            tick(); check_out();
        end
        push("collide_tick", 245, CTRL_DOWN, 1'b0, 9, 1'b1);
        collide = 1'b1; tick(); collide = 1'b0; check_out();
        push("fall1", 246, CTRL_DOWN, 1'b0, 9, 1'b1); tick(); check_out();
        push("fall2", 248, CTRL_DOWN, 1'b0, 9, 1'b1); tick(); check_out();
        push("fall_flap_ignored", 251, CTRL_DOWN, 1'b0, 9, 1'b1);
        flap = 1'b1; tick(); flap = 1'b0; check_out();
        my = 251; mv = 3; dead = 1'b0;
        for (int k = 0; k < 100 && !dead; k++) begin
            mv = (mv + 1 > 10) ? 10 : mv + 1;
            ny = my + mv;
            if (ny >= 448) begin
                dead = 1'b1;
                push("fall_dead", 448, CTRL_DOWN, 1'b0, 9, 1'b1);
            end else begin
                my = ny;
                push("fall_seq", my, CTRL_DOWN, 1'b0, 9, 1'b1);
            end
            tick();
            check_out();
        end
        chk("fall_floor_reached", 16'(dead), 16'd1);

        // Score saturation: flap every frame pins y0 at the ceiling.
        start = 1'b1; cyc(); start = 1'b0;
        push("idle_again", 200, CTRL_LIVE, 1'b0, 0, 1'b0); check_out();
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 1030; k++) begin
            flap = 1'b1; tick(); flap = 1'b0; cyc();
        end
        push("score_sat", 0, CTRL_LIVE, 1'b1, 1023, 1'b1); cyc(); check_out();
        push("sat_g1", 1, CTRL_LIVE, 1'b1, 1023, 1'b1); tick(); check_out();
        push("sat_g2", 3, CTRL_LIVE, 1'b1, 1023, 1'b1); tick(); check_out();
        push("sat_g3", 6, CTRL_LIVE, 1'b1, 1023, 1'b1); tick(); check_out();

        // Asynchronous reset mid-flight takes effect without a clock edge.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        push("async_reset", 200, CTRL_LIVE, 1'b0, 0, 1'b1); check_out();
        #2;
        reset_n = 1'b1;
        push("post_reset", 200, CTRL_LIVE, 1'b0, 0, 1'b1); cyc(); check_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
